mem_arbiter: RTL and testbench

Parametrised N-channel arbiter that shares one `Memory` command port among `NUM_PORTS` requesters, such as instruction fetch, data load/store and debug or DMA. It generalises the fixed two-channel, instruction-first memory interface with configurable port count, address and data widths, and a selectable round-robin or fixed-priority arbitration mode. Read data is returned with a registered per-port response pulse. It sits between the core's memory clients and the single-ported `Memory` instance.

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one Memory command port among NUM_PORTS requesters.
// Round-robin or fixed-priority grant; registered per-port read response.
module mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ARB_MODE   = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wmask,
    output logic [NUM_PORTS-1:0]            resp_valid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] resp_rdata,
    output logic                            mem_cmd_start,
    output logic                            mem_cmd_write,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic [DATA_WIDTH-1:0]           mem_wmask,
    input  logic                            mem_cmd_ready,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    input  logic                            mem_rdata_valid
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_READ
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [PW-1:0]         r_rr_ptr;
    logic [PW-1:0]         r_gnt;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_wmask;
    logic [NUM_PORTS-1:0]  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_rdata [NUM_PORTS];

    logic [ADDR_WIDTH-1:0] w_addr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] w_wdata [NUM_PORTS];
    logic [DATA_WIDTH-1:0] w_wmask [NUM_PORTS];
    logic [PW-1:0]         w_gnt;
    logic [PW-1:0]         w_idx;
    logic                  w_found;
    logic                  w_any;
    logic                  w_accept;
    logic                  w_start;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign w_addr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_wmask[g] = req_wmask[g*DATA_WIDTH +: DATA_WIDTH];
        assign resp_rdata[g*DATA_WIDTH +: DATA_WIDTH] = r_rdata[g];
    end

    assign w_any      = |req_valid;
    assign w_accept   = (r_state == IDLE) && w_any;
    assign resp_valid = r_resp_valid;

    // Scan starts at rr_ptr (round-robin) or at port 0 (fixed priority).
    always_comb begin
        w_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (ARB_MODE == 0) begin
                w_idx = PW'((int'(r_rr_ptr) + k) % NUM_PORTS);
            end else begin
                w_idx = PW'(k);
            end
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        req_ready     = '0;
        w_start       = 1'b0;
        mem_cmd_write = 1'b0;
        mem_addr      = '1;
        mem_wdata     = '1;
        mem_wmask     = '1;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    req_ready[w_gnt] = 1'b1;
                    if (mem_cmd_ready) begin
                        w_start       = 1'b1;
                        mem_cmd_write = req_write[w_gnt];
                        mem_addr      = w_addr[w_gnt];
                        mem_wdata     = w_wdata[w_gnt];
                        mem_wmask     = w_wmask[w_gnt];
                        w_next = req_write[w_gnt] ? IDLE : WAIT_READ;
                    end else begin
                        w_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                w_start       = mem_cmd_ready;
                mem_cmd_write = r_write;
                mem_addr      = r_addr;
                mem_wdata     = r_wdata;
                mem_wmask     = r_wmask;
                if (mem_cmd_ready) begin
                    w_next = r_write ? IDLE : WAIT_READ;
                end
            end
            WAIT_READ: begin
                if (mem_rdata_valid) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Never start a command while reset is held, even from IDLE.
    assign mem_cmd_start = w_start & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_gnt        <= '0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_resp_valid <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_rdata[i] <= '1;
            end
        end else begin
            r_state      <= w_next;
            r_resp_valid <= '0;
            if (w_accept) begin
                r_gnt   <= w_gnt;
                r_write <= req_write[w_gnt];
                r_addr  <= w_addr[w_gnt];
                r_wdata <= w_wdata[w_gnt];
                r_wmask <= w_wmask[w_gnt];
                if (ARB_MODE == 0) begin
                    if (w_gnt == PW'(NUM_PORTS - 1)) begin
                        r_rr_ptr <= '0;
                    end else begin
                        r_rr_ptr <= w_gnt + PW'(1);
                    end
                end
            end
            if (r_state == WAIT_READ && mem_rdata_valid) begin
                r_resp_valid[r_gnt] <= 1'b1;
                r_rdata[r_gnt]      <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: 2-port round-robin, 4-port round-robin and
// 4-port fixed-priority instances driven one at a time.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    int           sel;
    logic [3:0]   vdrv;
    logic [3:0]   wr;
    logic [127:0] addr_bus;
    logic [127:0] wdata_bus;
    logic [127:0] wmask_bus;
    logic         mem_cmd_ready;
    logic [31:0]  mem_rdata;
    logic         mem_rdata_valid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    logic [1:0]  v2;
    logic [3:0]  v4r, v4p;
    assign v2  = (sel == 0) ? vdrv[1:0] : 2'b00;
    assign v4r = (sel == 1) ? vdrv : 4'b0000;
    assign v4p = (sel == 2) ? vdrv : 4'b0000;

    logic [1:0]   o2_ready, o2_rv;
    logic [63:0]  o2_rdata;
    logic         o2_start, o2_write;
    logic [31:0]  o2_addr, o2_wdata, o2_wmask;
    logic [3:0]   or_ready, or_rv, op_ready, op_rv;
    logic [127:0] or_rdata, op_rdata;
    logic         or_start, or_write, op_start, op_write;
    logic [31:0]  or_addr, or_wdata, or_wmask;
    logic [31:0]  op_addr, op_wdata, op_wmask;

    mem_arbiter #(.NUM_PORTS(2), .ARB_MODE(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v2), .req_ready(o2_ready), .req_write(wr[1:0]),
        .req_addr(addr_bus[63:0]), .req_wdata(wdata_bus[63:0]),
        .req_wmask(wmask_bus[63:0]),
        .resp_valid(o2_rv), .resp_rdata(o2_rdata),
        .mem_cmd_start(o2_start), .mem_cmd_write(o2_write),
        .mem_addr(o2_addr), .mem_wdata(o2_wdata), .mem_wmask(o2_wmask),
        .mem_cmd_ready(mem_cmd_ready), .mem_rdata(mem_rdata),
        .mem_rdata_valid(mem_rdata_valid)
    );

    mem_arbiter #(.NUM_PORTS(4), .ARB_MODE(0)) u_dut4r (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v4r), .req_ready(or_ready), .req_write(wr),
        .req_addr(addr_bus), .req_wdata(wdata_bus),
        .req_wmask(wmask_bus),
        .resp_valid(or_rv), .resp_rdata(or_rdata),
        .mem_cmd_start(or_start), .mem_cmd_write(or_write),
        .mem_addr(or_addr), .mem_wdata(or_wdata), .mem_wmask(or_wmask),
        .mem_cmd_ready(mem_cmd_ready), .mem_rdata(mem_rdata),
        .mem_rdata_valid(mem_rdata_valid)
    );

    mem_arbiter #(.NUM_PORTS(4), .ARB_MODE(1)) u_dut4p (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v4p), .req_ready(op_ready), .req_write(wr),
        .req_addr(addr_bus), .req_wdata(wdata_bus),
        .req_wmask(wmask_bus),
        .resp_valid(op_rv), .resp_rdata(op_rdata),
        .mem_cmd_start(op_start), .mem_cmd_write(op_write),
        .mem_addr(op_addr), .mem_wdata(op_wdata), .mem_wmask(op_wmask),
        .mem_cmd_ready(mem_cmd_ready), .mem_rdata(mem_rdata),
        .mem_rdata_valid(mem_rdata_valid)
    );

    logic [3:0]   obs_ready, obs_rv;
    logic [127:0] obs_rdata;
    logic         obs_start, obs_write;
    logic [31:0]  obs_addr, obs_wdata, obs_wmask;

    always_comb begin
        obs_ready = or_ready;
        obs_rv    = or_rv;
        obs_rdata = or_rdata;
        obs_start = or_start;
        obs_write = or_write;
        obs_addr  = or_addr;
        obs_wdata = or_wdata;
        obs_wmask = or_wmask;
        if (sel == 0) begin
            obs_ready = {2'b00, o2_ready};
            obs_rv    = {2'b00, o2_rv};
            obs_rdata = {64'hFFFF_FFFF_FFFF_FFFF, o2_rdata};
            obs_start = o2_start;
            obs_write = o2_write;
            obs_addr  = o2_addr;
            obs_wdata = o2_wdata;
            obs_wmask = o2_wmask;
        end else if (sel == 2) begin
            obs_ready = op_ready;
            obs_rv    = op_rv;
            obs_rdata = op_rdata;
            obs_start = op_start;
            obs_write = op_write;
            obs_addr  = op_addr;
            obs_wdata = op_wdata;
            obs_wmask = op_wmask;
        end
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One read transaction with memory ready and data one cycle later.
    task automatic rd_txn(input logic [3:0] vv, input int g,
                          input logic [31:0] d, input int prev,
                          input logic [31:0] prev_d);
        @(negedge clk);
        vdrv = vv; wr = 4'b0000; mem_cmd_ready = 1'b1;
        mem_rdata_valid = 1'b0;
        #1;
        if (prev >= 0) begin
            check("resp_pulse", obs_rv, 128'(4'b0001 << prev));
            check("resp_data", obs_rdata[prev*32 +: 32], prev_d);
        end
        check("grant", obs_ready, 128'(4'b0001 << g));
        check("start", obs_start, 1);
        check("addr", obs_addr, 32'h1000 + 32'(4 * g));
        @(negedge clk);
        mem_rdata_valid = 1'b1; mem_rdata = d;
        #1;
        check("busy_ready", obs_ready, 0);
    endtask

    task automatic rd_done(input int prev, input logic [31:0] prev_d);
        @(negedge clk);
        vdrv = 4'b0000; mem_rdata_valid = 1'b0;
        #1;
        check("last_pulse", obs_rv, 128'(4'b0001 << prev));
        check("last_data", obs_rdata[prev*32 +: 32], prev_d);
    endtask

    initial begin
        rst_n = 1'b0; sel = 0; vdrv = 4'b0000; wr = 4'b0000;
        mem_cmd_ready = 1'b1; mem_rdata = '0; mem_rdata_valid = 1'b0;
        wmask_bus = '1;
        for (int i = 0; i < 4; i++) begin
            addr_bus[i*32 +: 32]  = 32'h1000 + 32'(4 * i);
            wdata_bus[i*32 +: 32] = 32'h5000 + 32'(i);
        end

        // Reset state, start gated while reset held.
        @(negedge clk);
        vdrv = 4'b0010;
        #1;
        check("rst_start", obs_start, 0);
        check("rst_rv", obs_rv, 0);
        check("rst_rdata", obs_rdata[63:0], 64'hFFFF_FFFF_FFFF_FFFF);

        // Single read on the 2-port instance, port 1.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("p1_ready", obs_ready, 4'b0010);
        check("p1_start", obs_start, 1);
        check("p1_addr", obs_addr, 32'h1004);
        check("p1_write", obs_write, 0);
        @(negedge clk);
        vdrv = 4'b0000;
        #1;
        check("p1_wait_start", obs_start, 0);
        check("p1_wait_addr", obs_addr, 32'hFFFF_FFFF);
        @(negedge clk);
        mem_rdata = 32'h1234_5678; mem_rdata_valid = 1'b1;
        #1;
        check("p1_no_early_rv", obs_rv, 0);
        @(negedge clk);
        mem_rdata_valid = 1'b0;
        #1;
        check("p1_rv", obs_rv, 4'b0010);
        check("p1_rdata1", obs_rdata[63:32], 32'h1234_5678);
        check("p1_rdata0", obs_rdata[31:0], 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        check("p1_rv_drop", obs_rv, 0);
        check("p1_hold", obs_rdata[63:32], 32'h1234_5678);

        // Round-robin, all four ports valid.
        sel = 1;
        rd_txn(4'hF, 0, 32'hD0, -1, 32'h0);
        rd_txn(4'hF, 1, 32'hD1, 0, 32'hD0);
        rd_txn(4'hF, 2, 32'hD2, 1, 32'hD1);
        rd_txn(4'hF, 3, 32'hD3, 2, 32'hD2);
        rd_txn(4'hF, 0, 32'hD4, 3, 32'hD3);
        rd_done(0, 32'hD4);

        // Fixed priority: port 0 wins until it drops.
        sel = 2;
        rd_txn(4'hF, 0, 32'hE0, -1, 32'h0);
        rd_txn(4'hF, 0, 32'hE1, 0, 32'hE0);
        rd_txn(4'hF, 0, 32'hE2, 0, 32'hE1);
        rd_txn(4'hE, 1, 32'hE3, 0, 32'hE2);
        rd_txn(4'hC, 2, 32'hE4, 1, 32'hE3);
        rd_txn(4'h8, 3, 32'hE5, 2, 32'hE4);
        rd_done(3, 32'hE5);

        // Write from port 2 with memory stalled (rr_ptr is 1 here).
        sel = 1;
        @(negedge clk);
        addr_bus[64 +: 32]  = 32'h40;
        wdata_bus[64 +: 32] = 32'hAABB_CCDD;
        vdrv = 4'b0100; wr = 4'b0100; mem_cmd_ready = 1'b0;
        #1;
        check("wr_accept", obs_ready, 4'b0100);
        check("wr_no_start", obs_start, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vdrv = 4'b0001; wr = 4'b0000;
            addr_bus[64 +: 32] = 32'h99; wdata_bus[64 +: 32] = 32'h0;
            #1;
            check("issue_start", obs_start, 0);
            check("issue_ready", obs_ready, 0);
            check("issue_addr", obs_addr, 32'h40);
            check("issue_write", obs_write, 1);
        end
        @(negedge clk);
        vdrv = 4'b0000; mem_cmd_ready = 1'b1;
        #1;
        check("issue_go", obs_start, 1);
        check("issue_go_wr", obs_write, 1);
        check("issue_wdata", obs_wdata, 32'hAABB_CCDD);
        check("issue_wmask", obs_wmask, 32'hFFFF_FFFF);
        @(negedge clk);
        addr_bus[64 +: 32] = 32'h1008; wdata_bus[64 +: 32] = 32'h5002;
        #1;
        check("wr_done_start", obs_start, 0);
        check("wr_done_write", obs_write, 0);
        check("wr_no_rv", obs_rv, 0);

        // Back-to-back writes from port 0.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vdrv = 4'b0001; wr = 4'b0001;
            wdata_bus[31:0] = 32'h1111_0000 + 32'(k);
            #1;
            check("b2b_ready", obs_ready, 4'b0001);
            check("b2b_start", obs_start, 1);
            check("b2b_wdata", obs_wdata, 32'h1111_0000 + 32'(k));
        end
        @(negedge clk);
        vdrv = 4'b0000; wr = 4'b0000;
        #1;
        check("b2b_idle", obs_start, 0);
        check("b2b_no_rv", obs_rv, 0);

        // Reset during WAIT_READ of a port-2 read (rr_ptr then 3).
        @(negedge clk);
        vdrv = 4'b0100;
        #1;
        check("rr_p2", obs_ready, 4'b0100);
        @(negedge clk);
        vdrv = 4'b0000;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_start", obs_start, 0);
        check("mid_rst_rv", obs_rv, 0);
        check("mid_rst_rdata", obs_rdata, {128{1'b1}});
        @(negedge clk);
        rst_n = 1'b1; mem_rdata = 32'hBAD; mem_rdata_valid = 1'b1;
        @(negedge clk);
        mem_rdata_valid = 1'b0; vdrv = 4'hF;
        #1;
        check("stray_rv", obs_rv, 0);
        check("stray_rdata", obs_rdata, {128{1'b1}});
        check("post_rst_grant", obs_ready, 4'b0001);
        @(negedge clk);
        vdrv = 4'b0000;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
